// File: rtl/fft_r22sdf_bfii.sv
// rtl/fft_r22sdf_bfii.sv - radix-2^2 SDF second butterfly (BFII) with stage-local sample counter
//
// Purpose: consumes the BFI sum/difference stream one complex sample per
// enabled clock, applies -j on the fourth quarter of each 4*FSR_LEN block,
// performs the delayed add/subtract butterfly and registers the result.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   en_i            input sample valid; all state advances only when high
//   x_re_i, x_im_i  DW-bit signed input sample
//   z_re_o, z_im_o  OW-bit signed registered output sample
//   valid_o         z_*_o carries a meaningful sample this cycle
//   ctr_o           counter value (block index) of the sample on z_*_o
//
// Optional feature macro: FFT_R22SDF_BFII_SCALE_EN
//   defined   -> OW = DW, butterfly output halved (arithmetic, floor)
//   undefined -> OW = DW+1, full-precision one-bit growth
module fft_r22sdf_bfii #(
  parameter int DW      = 25,
  parameter int FSR_LEN = 1,
  localparam int L      = $clog2(FSR_LEN),
  localparam int CW     = L + 2,
`ifdef FFT_R22SDF_BFII_SCALE_EN
  localparam int OW     = DW
`else
  localparam int OW     = DW + 1
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] x_re_i,
  input  logic signed [DW-1:0] x_im_i,
  output logic signed [OW-1:0] z_re_o,
  output logic signed [OW-1:0] z_im_o,
  output logic                 valid_o,
  output logic [CW-1:0]        ctr_o
);

  logic [CW-1:0] ctr;
  logic          filled;
  logic          sel;
  logic          rot;
  logic          fill_now;

  logic signed [DW:0] x_re_ext;
  logic signed [DW:0] x_im_ext;
  logic signed [DW:0] y_re;
  logic signed [DW:0] y_im;
  logic signed [DW:0] d_re;
  logic signed [DW:0] d_im;
  logic signed [DW:0] sum_re;
  logic signed [DW:0] sum_im;
  logic signed [DW:0] wr_re;
  logic signed [DW:0] wr_im;
  logic signed [DW:0] full_re;
  logic signed [DW:0] full_im;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;

  logic signed [DW:0] dl_re [FSR_LEN];
  logic signed [DW:0] dl_im [FSR_LEN];

  assign sel = ctr[L];
  assign rot = ctr[L+1] & ctr[L];

  // The delay line is full once FSR_LEN samples have entered; before the
  // first wrap that is exactly "ctr >= FSR_LEN", afterwards the sticky flag holds.
  assign fill_now = filled | (ctr >= CW'(FSR_LEN));

  assign x_re_ext = {x_re_i[DW-1], x_re_i};
  assign x_im_ext = {x_im_i[DW-1], x_im_i};

  // -j * (re + j*im) = im - j*re. Negating at DW+1 bits keeps -(-2^(DW-1)) exact.
  assign y_re = rot ? x_im_ext : x_re_ext;
  assign y_im = rot ? -x_re_ext : x_im_ext;

  assign d_re = dl_re[0];
  assign d_im = dl_im[0];

  // The exact sum needs DW+2 bits, but only bits [DW:0] are ever kept (either
  // directly, or [DW:1] after the halving), so DW+1-bit modular arithmetic
  // yields identical results.
  assign sum_re = d_re + y_re;
  assign sum_im = d_im + y_im;

  assign wr_re = sel ? (d_re - y_re) : y_re;
  assign wr_im = sel ? (d_im - y_im) : y_im;

  assign full_re = sel ? sum_re : d_re;
  assign full_im = sel ? sum_im : d_im;

`ifdef FFT_R22SDF_BFII_SCALE_EN
  assign out_re = full_re[DW:1];
  assign out_im = full_im[DW:1];
`else
  assign out_re = full_re;
  assign out_im = full_im;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctr     <= '0;
      filled  <= 1'b0;
      z_re_o  <= '0;
      z_im_o  <= '0;
      ctr_o   <= '0;
      valid_o <= 1'b0;
      for (int i = 0; i < FSR_LEN; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else begin
      valid_o <= en_i & fill_now;
      if (en_i) begin
        ctr    <= ctr + CW'(1);
        filled <= fill_now;
        z_re_o <= out_re;
        z_im_o <= out_im;
        ctr_o  <= ctr;
        for (int i = 0; i < FSR_LEN - 1; i++) begin
          dl_re[i] <= dl_re[i+1];
          dl_im[i] <= dl_im[i+1];
        end
        dl_re[FSR_LEN-1] <= wr_re;
        dl_im[FSR_LEN-1] <= wr_im;
      end
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_bfii.sv
// tb/tb_fft_r22sdf_bfii.sv - self-checking bench for fft_r22sdf_bfii (three parameterisations)
module tb_fft_r22sdf_bfii;

  localparam int DWA = 16;
  localparam int FA  = 2;
  localparam int DWB = 4;
  localparam int FB  = 1;
  localparam int DWC = 16;
  localparam int FC  = 4;
`ifdef FFT_R22SDF_BFII_SCALE_EN
  localparam int SC  = 1;
  localparam int OA  = DWA;
  localparam int OB  = DWB;
  localparam int OC  = DWC;
`else
  localparam int SC  = 0;
  localparam int OA  = DWA + 1;
  localparam int OB  = DWB + 1;
  localparam int OC  = DWC + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  int in_re [3];
  int in_im [3];

  logic signed [DWA-1:0] xa_re, xa_im;
  logic signed [DWB-1:0] xb_re, xb_im;
  logic signed [DWC-1:0] xc_re, xc_im;
  logic signed [OA-1:0]  za_re, za_im;
  logic signed [OB-1:0]  zb_re, zb_im;
  logic signed [OC-1:0]  zc_re, zc_im;
  logic va, vb, vc;
  logic [$clog2(FA)+1:0] ca;
  logic [$clog2(FB)+1:0] cb;
  logic [$clog2(FC)+1:0] cc;

  assign xa_re = DWA'(in_re[0]);
  assign xa_im = DWA'(in_im[0]);
  assign xb_re = DWB'(in_re[1]);
  assign xb_im = DWB'(in_im[1]);
  assign xc_re = DWC'(in_re[2]);
  assign xc_im = DWC'(in_im[2]);

  fft_r22sdf_bfii #(.DW(DWA), .FSR_LEN(FA)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .x_re_i(xa_re), .x_im_i(xa_im),
    .z_re_o(za_re), .z_im_o(za_im), .valid_o(va), .ctr_o(ca));
  fft_r22sdf_bfii #(.DW(DWB), .FSR_LEN(FB)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .x_re_i(xb_re), .x_im_i(xb_im),
    .z_re_o(zb_re), .z_im_o(zb_im), .valid_o(vb), .ctr_o(cb));
  fft_r22sdf_bfii #(.DW(DWC), .FSR_LEN(FC)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .x_re_i(xc_re), .x_im_i(xc_im),
    .z_re_o(zc_re), .z_im_o(zc_im), .valid_o(vc), .ctr_o(cc));

  // Reference model state, one slot per instance.
  int fsr [3];
  int dw  [3];
  int m_ctr [3];
  int m_n   [3];
  int dl_re [3][4];
  int dl_im [3][4];
  int e_re  [3];
  int e_im  [3];
  int e_ctr [3];
  int e_val [3];

  int vectors = 0;
  int miscompares = 0;

  bit capture = 0;
  int cap_re [$];
  int cap_im [$];
  int cap_ctr [$];
  int exp_re [7];
  int exp_im [7];

  bit prev_vc = 0;
  int prev_cc = 0;
  int wraps = 0;

  function automatic int wrap(int v, int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  task automatic chk(string tag, int obs, int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ctr[i] = 0;
      m_n[i]   = 0;
      e_re[i]  = 0;
      e_im[i]  = 0;
      e_ctr[i] = 0;
      e_val[i] = 0;
      for (int k = 0; k < 4; k++) begin
        dl_re[i][k] = 0;
        dl_im[i][k] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int quarter, yr, yi, dr, di, o_re, o_im, w_re, w_im;
      if (!en) begin
        e_val[i] = 0;
      end else begin
        quarter = m_ctr[i] / fsr[i];
        if (quarter == 3) begin
          yr = in_im[i];
          yi = -in_re[i];
        end else begin
          yr = in_re[i];
          yi = in_im[i];
        end
        dr = dl_re[i][0];
        di = dl_im[i][0];
        if (quarter % 2 == 1) begin
          o_re = dr + yr;
          o_im = di + yi;
          w_re = wrap(dr - yr, dw[i] + 1);
          w_im = wrap(di - yi, dw[i] + 1);
        end else begin
          o_re = dr;
          o_im = di;
          w_re = yr;
          w_im = yi;
        end
        if (SC == 1) begin
          e_re[i] = wrap(o_re >>> 1, dw[i]);
          e_im[i] = wrap(o_im >>> 1, dw[i]);
        end else begin
          e_re[i] = wrap(o_re, dw[i] + 1);
          e_im[i] = wrap(o_im, dw[i] + 1);
        end
        for (int k = 0; k < fsr[i] - 1; k++) begin
          dl_re[i][k] = dl_re[i][k+1];
          dl_im[i][k] = dl_im[i][k+1];
        end
        dl_re[i][fsr[i]-1] = w_re;
        dl_im[i][fsr[i]-1] = w_im;
        e_ctr[i] = m_ctr[i];
        e_val[i] = (m_n[i] >= fsr[i]) ? 1 : 0;
        m_ctr[i] = (m_ctr[i] + 1) % (4 * fsr[i]);
        m_n[i]++;
      end
    end
  endtask

  task automatic check_all();
    chk("a_re", int'(za_re), e_re[0]);
    chk("a_im", int'(za_im), e_im[0]);
    chk("a_ctr", int'(ca), e_ctr[0]);
    chk("a_valid", int'(va), e_val[0]);
    chk("b_re", int'(zb_re), e_re[1]);
    chk("b_im", int'(zb_im), e_im[1]);
    chk("b_ctr", int'(cb), e_ctr[1]);
    chk("b_valid", int'(vb), e_val[1]);
    chk("c_re", int'(zc_re), e_re[2]);
    chk("c_im", int'(zc_im), e_im[2]);
    chk("c_ctr", int'(cc), e_ctr[2]);
    chk("c_valid", int'(vc), e_val[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_all();
    if (capture && va) begin
      cap_re.push_back(int'(za_re));
      cap_im.push_back(int'(za_im));
      cap_ctr.push_back(int'(ca));
    end
    if (vc && prev_vc && prev_cc == 15 && int'(cc) == 0) wraps++;
    prev_vc = vc;
    prev_cc = int'(cc);
  endtask

  // Asynchronous assertion away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_c();
    in_re[2] = int'($urandom_range(0, 65535)) - 32768;
    in_im[2] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic rand_all();
    in_re[0] = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
    in_im[0] = int'($urandom_range(0, 65535)) - 32768;
    in_re[1] = ($urandom_range(0, 3) == 0) ? -8 : int'($urandom_range(0, 15)) - 8;
    in_im[1] = int'($urandom_range(0, 15)) - 8;
    rand_c();
  endtask

  // A gets (n,0); B gets the most-negative sample; C random.
  task automatic run_stream(bit gap, int count);
    for (int n = 0; n < count; n++) begin
      in_re[0] = n;
      in_im[0] = 0;
      in_re[1] = -8;
      in_im[1] = -8;
      rand_c();
      en = 1'b1;
      tick();
      if (gap && n == 4) begin
        en = 1'b0;
        repeat (3) tick();
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic check_capture(string tag);
    chk({tag, "_count"}, cap_re.size(), 7);
    chk({tag, "_first_ctr"}, (cap_ctr.size() > 0) ? cap_ctr[0] : -1, 2);
    for (int k = 0; k < 7; k++) begin
      chk({tag, "_re"}, (k < cap_re.size()) ? cap_re[k] : 32'h7fffffff, exp_re[k]);
      chk({tag, "_im"}, (k < cap_im.size()) ? cap_im[k] : 32'h7fffffff, exp_im[k]);
    end
    cap_re.delete();
    cap_im.delete();
    cap_ctr.delete();
  endtask

  initial begin
    fsr = '{FA, FB, FC};
    dw  = '{DWA, DWB, DWC};
    for (int i = 0; i < 3; i++) begin
      in_re[i] = 0;
      in_im[i] = 0;
    end
`ifdef FFT_R22SDF_BFII_SCALE_EN
    exp_re = '{1, 2, -1, -1, 2, 2, 2};
    exp_im = '{0, 0, 0, 0, -3, -4, 3};
`else
    exp_re = '{2, 4, -2, -2, 4, 5, 4};
    exp_im = '{0, 0, 0, 0, -6, -7, 6};
`endif
    en  = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    tick();
    rst = 1'b0;
    tick();

    // Continuous directed stream.
    capture = 1;
    run_stream(1'b0, 9);
    capture = 0;
    check_capture("stream");

    // Same stream with a 3-cycle enable gap between samples 4 and 5.
    do_reset();
    capture = 1;
    run_stream(1'b1, 9);
    capture = 0;
    check_capture("gap");

    // Mid-block asynchronous reset at sample 5, then restart from index 0.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      in_re[0] = n;
      in_im[0] = 0;
      rand_c();
      en = 1'b1;
      tick();
    end
    do_reset();
    capture = 1;
    run_stream(1'b0, 9);
    capture = 0;
    check_capture("restart");

    // Randomised traffic with enable gaps.
    for (int n = 0; n < 200; n++) begin
      rand_all();
      en = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Continuous traffic across several FSR_LEN=4 blocks.
    do_reset();
    for (int n = 0; n < 64; n++) begin
      rand_all();
      en = 1'b1;
      tick();
    end
    en = 1'b0;
    tick();
    chk("c_wrap_seen", (wraps >= 3) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
